fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Stage 1 (IF) of the 5-stage RV32I pipeline; feeds stage 2 (decode, which reads regs).
//  Owns the PC, drives the instruction-memory strobe/ack handshake, absorbs decode stalls
//  with a one-entry skid buffer, and honours redirects from execute/trap logic.
//  Presents one {pc, instr, valid} beat per cycle to the IF/ID boundary.
// PARAMETERS
//  PC_RESET   0  PC loaded on reset; first fetch address
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  instr_addr   out  32  fetch address; [1:0] always 2'b00
//  instr_stb    out  1   fetch request; held with instr_addr stable until instr_ack
//  instr_ack    in   1   memory response valid; instr valid same cycle
//  instr        in   32  fetched instruction word
//  stall        in   1   decode cannot accept this cycle (hazard unit)
//  redirect_en  in   1   taken branch/jump/trap/mret; flush and refetch
//  redirect_pc  in   32  new PC; bits [1:0] ignored
//  if_valid     out  1   if_pc/if_instr hold a live instruction
//  if_pc        out  32  PC of if_instr
//  if_instr     out  32  instruction to decode
// BEHAVIOUR
//  Reset (rst=1 at edge): pc=PC_RESET, state=FETCH, instr_stb=0 while rst high,
//   if_valid=0, if_pc=0, if_instr=NOP (32'h0000_0013), skid empty, drop flag clear.
//  States: FETCH (stb=1), HOLD (stb=0, skid full), DROP (stb=1, response to be discarded).
//  instr_addr=pc in all states; pc changes only on ack acceptance or redirect.
//  Output consumed when if_valid && !stall; output free = !if_valid || !stall.
//  FETCH, ack, no redirect: output free -> out<={pc,instr}, if_valid=1 next cycle;
//   output not free -> skid<={pc,instr}, go HOLD. pc<=pc+4 in both (32-bit wrap FFFFFFFC->0).
//  FETCH, no ack, output consumed: if_valid<=0 (bubble). Latency: ack at cycle N -> if_valid at N+1.
//  HOLD: stb=0; when !stall, out<=skid, skid empty, go FETCH.
//  Redirect (highest priority, any state): if_valid<=0, skid emptied, pc<={redirect_pc[31:2],2'b00}.
//   FETCH w/ ack same cycle or HOLD: ack data dropped, go FETCH next cycle with new pc.
//   FETCH w/o ack (request outstanding): go DROP; keep old addr/stb until ack; then FETCH new pc.
//   DROP w/ second redirect: latest redirect_pc wins; stays DROP.
//  stall ignored while if_valid=0; stall with redirect: redirect wins.
//  Never more than one outstanding request; stb never drops before ack except via rst.
//  Reset mid-request: state cleared; a late ack after reset is ignored only if it arrives
//   while rst=1 (memory is reset by same rst).
// STRUCTURE
//  core_pkg: fetch_state_t enum {FETCH, HOLD, DROP}, NOP_INSTR=32'h0000_0013, XLEN=32.
//  Single module; skid buffer inline (2x32 + valid), no sub-module.
//  Instantiated in core; instr_addr/instr_stb/instr_ack wired to core ports.
// TESTING
//  1 Reset, ack every cycle, no stall -> instr_addr 0,4,8,C; if_pc 0,4,8 one cycle behind.
//  2 Ack at 0x8 while if_valid&&stall for 3 cycles -> HOLD, stb=0 3 cycles; on release
//    if_pc=0x4 consumed then if_pc=0x8 next; no instruction lost or duplicated.
//  3 Redirect to 0x100 while request at 0x10 outstanding, ack 2 cycles later ->
//    stb held on 0x10 until ack, data dropped (if_valid=0), next instr_addr=0x100.
//  4 Redirect to 0x203 with ack same cycle -> ack data dropped, next instr_addr=0x200.
//  5 PC_RESET=32'hFFFF_FFFC, ack -> next instr_addr=0x0 (wrap).
//  6 rst asserted during HOLD -> next cycle if_valid=0, if_instr=NOP, instr_addr=PC_RESET.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  // Force a fetch address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory strobe/ack bus between the fetch stage and memory.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [XLEN-1:0] instr_addr;
  logic            instr_stb;
  logic            instr_ack;
  logic [XLEN-1:0] instr;

  modport master (output instr_addr, output instr_stb, input instr_ack, input instr);
  modport slave  (input instr_addr, input instr_stb, output instr_ack, output instr);

endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the imem handshake, absorbs decode stalls in a
// one-entry skid buffer and discards responses made stale by a redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  fetch_stage_if.master   imem,
  input  logic            stall_i,
  input  logic            redirect_en_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;

  logic            out_free;
  logic            consume;
  logic [XLEN-1:0] redirect_tgt;

  assign out_free     = !out_valid_q || !stall_i;
  assign consume      = out_valid_q && !stall_i;
  assign redirect_tgt = word_align(redirect_pc_i);

  // While a stale request is in flight (DROP) pc_q keeps the old address;
  // the redirect target waits in tgt_q until that response arrives.
  assign imem.instr_addr = pc_q;
  assign imem.instr_stb  = !rst_i && (state_q != HOLD);

  assign if_valid_o = out_valid_q;
  assign if_pc_o    = out_pc_q;
  assign if_instr_o = out_instr_q;

  // Next-state, PC, skid and output-register selection.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;

    case (state_q)
      FETCH: begin
        if (redirect_en_i) begin
          out_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
          if (imem.instr_ack) begin
            pc_d    = redirect_tgt;
            state_d = FETCH;
          end else begin
            tgt_d   = redirect_tgt;
            state_d = DROP;
          end
        end else if (imem.instr_ack) begin
          pc_d = pc_q + 32'd4;
          if (out_free) begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = imem.instr;
          end else begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_q;
            skid_instr_d = imem.instr;
            state_d      = HOLD;
          end
        end else if (consume) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      HOLD: begin
        if (redirect_en_i) begin
          out_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
          pc_d         = redirect_tgt;
          state_d      = FETCH;
        end else if (!stall_i) begin
          out_valid_d  = skid_valid_q;
          out_pc_d     = skid_pc_q;
          out_instr_d  = skid_instr_q;
          skid_valid_d = 1'b0;
          state_d      = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DROP: begin
        out_valid_d  = 1'b0;
        skid_valid_d = 1'b0;
        if (redirect_en_i) begin
          tgt_d = redirect_tgt;
        end else begin
          tgt_d = tgt_q;
        end
        if (imem.instr_ack) begin
          pc_d    = redirect_en_i ? redirect_tgt : tgt_q;
          state_d = FETCH;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        out_valid_d  = 1'b0;
        skid_valid_d = 1'b0;
        state_d      = FETCH;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FETCH;
      pc_q         <= PC_RESET;
      tgt_q        <= 32'h0000_0000;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0000_0000;
      skid_instr_q <= NOP_INSTR;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 32'h0000_0000;
      out_instr_q  <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
    end
  end

endmodule
